// File: rtl/cpu_pkg.sv
// Shared widths and RAM-owner encoding for the CPU datapath blocks.
package cpu_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;
endpackage

// File: rtl/ram_arb_select.sv
// Combinational RAM winner select and loader starvation counter update.
module ram_arb_select
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic              i_prog_mode,
    input  logic              i_cpu_req,
    input  logic              i_ld_valid,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output owner_e            o_owner,
    output logic [WAIT_W-1:0] o_wait_cnt_next
);

    always_comb begin
        o_owner = OWN_NONE;
        if (i_prog_mode) begin
            if (i_ld_valid) o_owner = OWN_LD;
        end else if (i_cpu_req && i_ld_valid) begin
            // CPU has priority until the loader has been starved long enough
            o_owner = (int'(i_wait_cnt) >= MAX_WAIT) ? OWN_LD : OWN_CPU;
        end else if (i_cpu_req) begin
            o_owner = OWN_CPU;
        end else if (i_ld_valid) begin
            o_owner = OWN_LD;
        end
    end

    always_comb begin
        o_wait_cnt_next = '0;
        if (i_ld_valid && (o_owner != OWN_LD)) begin
            o_wait_cnt_next = (i_wait_cnt == '1) ? i_wait_cnt : i_wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the 16x8 program/data RAM between the CPU sequencer and the program loader.
module ram_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              ld_valid,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    owner_e              w_owner;
    logic [WAIT_W-1:0]   w_wait_next;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_cpu_gnt;
    logic                r_ram_ce_n;
    logic                r_ram_we_n;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_rd_cpu;
    logic                r_rd_ld;
    logic                r_cpu_rvalid;
    logic                r_ld_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    ram_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_select (
        .i_prog_mode     (prog_mode),
        .i_cpu_req       (cpu_req),
        .i_ld_valid      (ld_valid),
        .i_wait_cnt      (r_wait_cnt),
        .o_owner         (w_owner),
        .o_wait_cnt_next (w_wait_next)
    );

    assign w_we    = (w_owner == OWN_LD) ? ld_we    : cpu_we;
    assign w_addr  = (w_owner == OWN_LD) ? ld_addr  : cpu_addr;
    assign w_wdata = (w_owner == OWN_LD) ? ld_wdata : cpu_wdata;

    // Handshake outputs stay quiet while reset is held
    assign ld_ready  = rst_n && (w_owner == OWN_LD);
    assign cpu_stall = rst_n && cpu_req && (w_owner != OWN_CPU);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt   <= '0;
            r_cpu_gnt    <= 1'b0;
            r_ram_ce_n   <= 1'b1;
            r_ram_we_n   <= 1'b1;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_rd_cpu     <= 1'b0;
            r_rd_ld      <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_ld_rvalid  <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_wait_cnt   <= w_wait_next;
            r_cpu_rvalid <= r_rd_cpu;
            r_ld_rvalid  <= r_rd_ld;
            if (r_rd_cpu || r_rd_ld) r_rdata <= ram_rdata;

            if (w_owner != OWN_NONE) begin
                r_ram_ce_n  <= 1'b0;
                r_ram_we_n  <= !w_we;
                r_ram_addr  <= w_addr;
                r_ram_wdata <= w_wdata;
                r_cpu_gnt   <= (w_owner == OWN_CPU);
                r_rd_cpu    <= (w_owner == OWN_CPU) && !w_we;
                r_rd_ld     <= (w_owner == OWN_LD) && !w_we;
            end else begin
                r_ram_ce_n  <= 1'b1;
                r_ram_we_n  <= 1'b1;
                r_cpu_gnt   <= 1'b0;
                r_rd_cpu    <= 1'b0;
                r_rd_ld     <= 1'b0;
            end
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ld_rvalid  = r_ld_rvalid;
    assign rdata      = r_rdata;
    assign ram_ce_n   = r_ram_ce_n;
    assign ram_we_n   = r_ram_we_n;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a read-return scoreboard and RAM model.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_mode;
    logic       cpu_req, cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt, cpu_rvalid, cpu_stall;
    logic       ld_valid, ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       ld_ready, ld_rvalid;
    logic [7:0] rdata;
    logic       ram_ce_n, ram_we_n;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    typedef struct packed {
        logic       is_cpu;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow[16];
    logic [7:0] mem[16];
    logic       mem_loaded = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .MAX_WAIT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_mode  (prog_mode),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_stall  (cpu_stall),
        .ld_valid   (ld_valid),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ready   (ld_ready),
        .ld_rvalid  (ld_rvalid),
        .rdata      (rdata),
        .ram_ce_n   (ram_ce_n),
        .ram_we_n   (ram_we_n),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 9) ? 8'h3C : 8'(8'h10 + i);
    endfunction

    // Asynchronous-read RAM: data follows the registered address within the cycle
    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (!ram_ce_n && !ram_we_n) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid || ld_rvalid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'({cpu_rvalid, ld_rvalid}), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_owner", 32'({cpu_rvalid, ld_rvalid}), 32'({e.is_cpu, !e.is_cpu}));
                chk("rd_data", 32'(rdata), 32'(e.data));
                $display("read return owner=%s data=%02h expected=%02h",
                         cpu_rvalid ? "cpu" : "ld", rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        rst_n = 1'b0; prog_mode = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1; cpu_wdata = 8'h00;
        ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 4'h2; ld_wdata = 8'h00;

        // Reset with both requesters active
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce_n", 32'(ram_ce_n), 32'h1);
        chk("rst_we_n", 32'(ram_we_n), 32'h1);
        chk("rst_stall", 32'(cpu_stall), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_valids", 32'({cpu_gnt, cpu_rvalid, ld_rvalid}), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        rst_n = 1'b1; cpu_req = 1'b0; ld_valid = 1'b0;
        tick();
        $display("reset sequence done");

        // CPU read of address 9
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h9;
        sb.push_back('{is_cpu: 1'b1, data: shadow[9]});
        #1;
        chk("cpu_rd_stall", 32'(cpu_stall), 32'h0);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("cpu_rd_gnt", 32'(cpu_gnt), 32'h1);
        chk("cpu_rd_strobes", 32'({ram_ce_n, ram_we_n}), 32'h1);
        chk("cpu_rd_addr", 32'(ram_addr), 32'h9);
        chk("cpu_rd_stall2", 32'(cpu_stall), 32'h0);
        tick();
        chk("cpu_rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("cpu_rd_rdata", 32'(rdata), 32'h3C);
        chk("cpu_rd_idle_ce", 32'(ram_ce_n), 32'h1);

        // Program mode: loader fills the RAM while the CPU is locked out
        prog_mode = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0;
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 4'(i); ld_wdata = 8'(8'hA0 + i);
            shadow[i] = 8'(8'hA0 + i);
            #1;
            chk("prog_ready", 32'(ld_ready), 32'h1);
            chk("prog_stall", 32'(cpu_stall), 32'h1);
            tick();
            chk("prog_strobes", 32'({ram_ce_n, ram_we_n, cpu_gnt}), 32'h0);
            chk("prog_addr", 32'(ram_addr), 32'(i));
            chk("prog_wdata", 32'(ram_wdata), 32'(8'hA0 + i));
            $display("loader write addr=%0h data=%02h", i, ld_wdata);
        end
        ld_valid = 1'b0; prog_mode = 1'b0; cpu_req = 1'b0;
        tick();
        chk("prog_end_ce", 32'(ram_ce_n), 32'h1);
        chk("prog_end_we", 32'(ram_we_n), 32'h1);

        // Continuous contention: CPU,CPU,CPU,LD
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 4'h5;
        for (int i = 0; i < 8; i++) begin
            logic ld_win;
            ld_win = ((i % 4) == 3);
            if (ld_win) sb.push_back('{is_cpu: 1'b0, data: shadow[5]});
            else        sb.push_back('{is_cpu: 1'b1, data: shadow[3]});
            #1;
            chk("cont_stall", 32'(cpu_stall), 32'(ld_win));
            chk("cont_ready", 32'(ld_ready), 32'(ld_win));
            tick();
            chk("cont_gnt", 32'(cpu_gnt), 32'(!ld_win));
            chk("cont_addr", 32'(ram_addr), ld_win ? 32'h5 : 32'h3);
        end
        cpu_req = 1'b0; ld_valid = 1'b0;
        tick();
        tick();

        // Loader read of addr 2, then CPU overwrites it, then CPU reads it back
        ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 4'h2;
        sb.push_back('{is_cpu: 1'b0, data: shadow[2]});
        #1;
        chk("mix_ld_ready", 32'(ld_ready), 32'h1);
        tick();
        ld_valid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h2; cpu_wdata = 8'h55;
        shadow[2] = 8'h55;
        #1;
        chk("mix_wr_stall", 32'(cpu_stall), 32'h0);
        tick();
        chk("mix_wr_strobes", 32'({ram_ce_n, ram_we_n, cpu_gnt}), 32'h1);
        chk("mix_wr_data", 32'(ram_wdata), 32'h55);
        cpu_we = 1'b0;
        sb.push_back('{is_cpu: 1'b1, data: shadow[2]});
        tick();
        cpu_req = 1'b0;
        tick();
        tick();

        // Reset arriving while a CPU read is in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h9;
        tick();
        chk("rstmid_gnt", 32'(cpu_gnt), 32'h1);
        rst_n = 1'b0; cpu_req = 1'b0;
        tick();
        chk("rstmid_valids", 32'({cpu_gnt, cpu_rvalid, ld_rvalid}), 32'h0);
        chk("rstmid_strobes", 32'({ram_ce_n, ram_we_n}), 32'h3);
        chk("rstmid_rdata", 32'(rdata), 32'h0);
        chk("rstmid_addr", 32'(ram_addr), 32'h0);
        chk("rstmid_wdata", 32'(ram_wdata), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rstmid_rvalid_after", 32'(cpu_rvalid), 32'h0);
        tick();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 16 x 8 program/data RAM between two requesters: the CPU datapath and the external program loader.
- The CPU side is driven by the control sequencer (fetch, LDA, STA). The loader side writes or reads back program bytes over a valid/ready handshake.
- The block registers one RAM access per cycle. It returns read data to the owning requester and raises cpu_stall so the control sequencer freezes its T-state counter while the CPU is denied.

Parameters:
ADDR_W, 4, RAM address width (16 words)
DATA_W, 8, RAM/bus data width
MAX_WAIT, 3, consecutive cycles the loader may be denied before it is forced ahead of the CPU (range 1..15)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous, active-low reset
prog_mode  input  1  1 = loader owns RAM exclusively, CPU never granted
cpu_req  input  1  CPU requests a RAM access this cycle
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address (from MAR)
cpu_wdata  input  DATA_W  CPU write data (from bus)
cpu_gnt  output  1  CPU access issued this cycle (registered)
cpu_rvalid  output  1  cpu read data valid
cpu_stall  output  1  CPU requesting but not granted; sequencer holds stage
ld_valid  input  1  loader request
ld_we  input  1  1 = write, 0 = read
ld_addr  input  ADDR_W  loader address
ld_wdata  input  DATA_W  loader write data
ld_ready  output  1  loader request accepted this cycle (combinational from arbitration)
ld_rvalid  output  1  loader read data valid
rdata  output  DATA_W  read data, qualified by cpu_rvalid/ld_rvalid
ram_ce_n  output  1  RAM chip enable, active low
ram_we_n  output  1  RAM write strobe, active low
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, valid one cycle after ce_n low with we_n high

Behaviour:
- Reset values: cpu_gnt=0, cpu_rvalid=0, ld_rvalid=0, ram_ce_n=1, ram_we_n=1, ram_addr=0, ram_wdata=0, rdata=0, wait_cnt=0.
- cpu_stall and ld_ready are 0 while rst_n=0.
- Winner is decided combinationally each cycle from cpu_req, ld_valid, prog_mode and wait_cnt:
  - prog_mode=1: loader wins if ld_valid; CPU never wins.
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless wait_cnt >= MAX_WAIT, in which case the loader wins.
- ld_ready = loader wins.
- cpu_stall = cpu_req && !(CPU wins).
- Issue, cycle N to N+1 edge: register the winner's addr, wdata and we into the ram_* outputs. ram_ce_n=0; ram_we_n = !we; cpu_gnt = (CPU won).
- No winner: ram_ce_n=1, ram_we_n=1; address and wdata hold their previous values.
- Read return: rvalid for the owner asserts one cycle after issue, with rdata = ram_rdata registered at that point. Reads therefore complete 2 cycles after request.
- A write produces no rvalid.
- wait_cnt:
  - Increments (saturating at 15) each cycle ld_valid=1 and the loader loses.
  - Clears to 0 when the loader wins or ld_valid=0.
- Back-to-back accesses are allowed every cycle; there are no bubbles between owners.
- prog_mode change takes effect the same cycle (combinational arbitration). An access already issued completes normally.
- Reset mid-access: outputs return to reset values at the reset edge. Strobes issued in the previous cycle are already presented to the RAM and complete; the associated rvalid is suppressed.
- Loader must hold ld_* stable until ld_ready; the CPU holds cpu_* stable while cpu_stall=1.
- Addresses wrap naturally in ADDR_W bits; there is no range checking.

Decomposition:
- Shared package (cpu_pkg): ADDR_W/DATA_W defaults and the owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_LD=2'd2.
- One natural sub-module: ram_arb_select. It is purely combinational and holds the winner select plus the wait_cnt update logic.
- The issue/return registers stay in ram_port_arbiter.

Test Plan:
- Reset: hold rst_n=0 with cpu_req=1 and ld_valid=1 -> ram_ce_n=1, cpu_stall=0, ld_ready=0, all valids 0.
- CPU read only: cpu_req=1, we=0, addr=4'h9, RAM[9]=8'h3C -> cpu_gnt=1 at N+1, cpu_rvalid=1 and rdata=8'h3C at N+2, cpu_stall=0 throughout.
- prog_mode=1 loader writes addr 0..15 with data 8'hA0+i, one per cycle -> ld_ready=1 every cycle, ram_we_n=0 for 16 consecutive cycles. CPU cpu_req=1 concurrently sees cpu_stall=1 throughout.
- Contention with MAX_WAIT=3: both requesters active continuously -> CPU wins 3 cycles, loader wins the 4th. Pattern repeats: CPU,CPU,CPU,LD; cpu_stall=1 only in the LD cycles.
- Mixed: loader read addr 4'h2 immediately followed by CPU write addr 4'h2 = 8'h55 -> ld_rvalid carries the old value; a subsequent CPU read returns 8'h55.
- Reset mid-read: issue CPU read, assert rst_n=0 next cycle -> cpu_rvalid stays 0, all outputs at reset values.
